// File: rtl/llmint8_pkg.sv
// Shared types and helpers for the int8 quantisation path.
// Used by fixed_absmax_row_scheduler and fixed_max_accumulator.
package llmint8_pkg;

  // Row scheduler FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_EMIT  = 2'd3
  } absmax_state_t;

  // Number of tree-width chunks that make up one row.
  function automatic int absmax_chunks(input int row_size, input int in_size);
    return row_size / in_size;
  endfunction

  // Largest positive magnitude representable in a signed in_width-bit value.
  function automatic int ABSMAX_SAT(input int in_width);
    return (1 << (in_width - 1)) - 1;
  endfunction

endpackage

// File: rtl/fixed_max_accumulator.sv
// Running unsigned max of chunk magnitudes for one row.
// Optional build macro: ABSMAX_SATURATE_EN folds the overflowed magnitude
// 2^(IN_WIDTH-1) as 2^(IN_WIDTH-1)-1 so the result fits the signed range.
module fixed_max_accumulator
  import llmint8_pkg::*;
#(
  parameter int IN_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                load,
  input  logic                update,
  input  logic [IN_WIDTH-1:0] value,
  output logic [IN_WIDTH-1:0] acc
);

  logic [IN_WIDTH-1:0] value_fold;

`ifdef ABSMAX_SATURATE_EN
  localparam logic [IN_WIDTH-1:0] OVF_MAG = {1'b1, {(IN_WIDTH-1){1'b0}}};
  localparam logic [IN_WIDTH-1:0] SAT_MAG = IN_WIDTH'(ABSMAX_SAT(IN_WIDTH));

  // Clamp abs(most-negative) to the largest positive magnitude.
  always_comb begin
    value_fold = (value == OVF_MAG) ? SAT_MAG : value;
  end
`else
  // Magnitude folded unchanged, including 2^(IN_WIDTH-1).
  always_comb begin
    value_fold = value;
  end
`endif

  // Accumulator register: clear wins, first return loads, later returns keep the max.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (load) begin
      acc <= value_fold;
    end else if (update && (value_fold > acc)) begin
      acc <= value_fold;
    end
  end

endmodule

// File: rtl/fixed_absmax_row_scheduler.sv
// Feeds one row through a pipelined comparator tree chunk by chunk, limits
// chunks in flight with credits, and folds the returned magnitudes into the
// row absmax. Optional build macro: ABSMAX_SATURATE_EN (see accumulator).
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | no row active, counters at zero, waiting for first chunk
// ST_FEED  | chunks being issued, returns folded as they arrive
// ST_DRAIN | all chunks issued, waiting for remaining returns
// ST_EMIT  | row_max valid and held until accepted
module fixed_absmax_row_scheduler
  import llmint8_pkg::*;
#(
  parameter int IN_SIZE         = 4,
  parameter int IN_WIDTH        = 16,
  parameter int ROW_SIZE        = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [IN_SIZE-1:0][IN_WIDTH-1:0] data_in,
  input  logic                             data_in_valid,
  output logic                             data_in_ready,
  output logic [IN_SIZE-1:0][IN_WIDTH-1:0] tree_in,
  output logic                             tree_in_valid,
  input  logic                             tree_in_ready,
  input  logic [IN_WIDTH-1:0]              tree_out,
  input  logic                             tree_out_valid,
  output logic                             tree_out_ready,
  output logic [IN_WIDTH-1:0]              row_max,
  output logic                             row_max_valid,
  input  logic                             row_max_ready,
  output logic                             row_busy
);

  localparam int CHUNKS = absmax_chunks(ROW_SIZE, IN_SIZE);
  localparam int CNT_W  = $clog2(CHUNKS + 1);
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [CNT_W-1:0] CHUNKS_C  = CNT_W'(CHUNKS);
  localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(CHUNKS - 1);
  localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUTSTANDING);

  absmax_state_t    state_q, state_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] returned_q, returned_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;

  logic can_issue;
  logic issue_fire;
  logic ret_fire;
  logic row_accept;
  logic [IN_WIDTH-1:0] acc;

  // Issue is allowed only before the row is fully issued and while credits remain.
  // Credits depend on registered state only, so tree_out_valid never reaches data_in_ready.
  always_comb begin
    can_issue = ((state_q == ST_IDLE) || (state_q == ST_FEED)) &&
                (issued_q < CHUNKS_C) && (outstanding_q < MAX_OUT_C);
  end

  // Handshake decode; rst gating keeps the tree quiet while reset is held.
  always_comb begin
    tree_in        = data_in;
    tree_in_valid  = rst && data_in_valid && can_issue;
    data_in_ready  = rst && tree_in_ready && can_issue;
    tree_out_ready = (state_q == ST_FEED) || (state_q == ST_DRAIN);
    issue_fire     = tree_in_valid && tree_in_ready;
    ret_fire       = tree_out_valid && tree_out_ready;
    row_accept     = (state_q == ST_EMIT) && row_max_ready;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (issue_fire) begin
          state_d = (issued_q == LAST_C) ? ST_DRAIN : ST_FEED;
        end
      end
      ST_FEED: begin
        if (issue_fire && (issued_q == LAST_C)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (ret_fire && (returned_q == LAST_C)) begin
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (row_max_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Chunk and credit counters; an issue and a return together cancel on outstanding.
  always_comb begin
    issued_d      = issued_q;
    returned_d    = returned_q;
    outstanding_d = outstanding_q;
    if (row_accept) begin
      issued_d   = '0;
      returned_d = '0;
    end else begin
      if (issue_fire) begin
        issued_d = issued_q + CNT_W'(1);
      end
      if (ret_fire) begin
        returned_d = returned_q + CNT_W'(1);
      end
    end
    case ({issue_fire, ret_fire})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      issued_q      <= '0;
      returned_q    <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      issued_q      <= issued_d;
      returned_q    <= returned_d;
      outstanding_q <= outstanding_d;
    end
  end

  fixed_max_accumulator #(
    .IN_WIDTH (IN_WIDTH)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clear  (row_accept),
    .load   (ret_fire && (returned_q == '0)),
    .update (ret_fire),
    .value  (tree_out),
    .acc    (acc)
  );

  // Result hand-off straight from registered state; acc is frozen in EMIT.
  always_comb begin
    row_max       = acc;
    row_max_valid = (state_q == ST_EMIT);
    row_busy      = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_fixed_absmax_row_scheduler.sv
// Bench for fixed_absmax_row_scheduler: a modelled pipelined tree with
// configurable latency, randomised handshakes, and a row absmax reference
// computed directly from the element values.
module tb_fixed_absmax_row_scheduler;

  localparam int IN_SIZE  = 4;
  localparam int IN_WIDTH = 16;
  localparam int ROW_SIZE = 16;
  localparam int MAX_OUT  = 2;
  localparam int CHUNKS   = ROW_SIZE / IN_SIZE;

  typedef logic [IN_SIZE-1:0][IN_WIDTH-1:0] chunk_t;

  logic                clk = 1'b0;
  logic                rst;
  chunk_t              data_in;
  logic                data_in_valid;
  logic                data_in_ready;
  chunk_t              tree_in;
  logic                tree_in_valid;
  logic                tree_in_ready;
  logic [IN_WIDTH-1:0] tree_out;
  logic                tree_out_valid;
  logic                tree_out_ready;
  logic [IN_WIDTH-1:0] row_max;
  logic                row_max_valid;
  logic                row_max_ready;
  logic                row_busy;

  int n_cmp = 0;
  int n_bad = 0;

  chunk_t row_data [CHUNKS];

  always #5 clk = ~clk;

  fixed_absmax_row_scheduler #(
    .IN_SIZE         (IN_SIZE),
    .IN_WIDTH        (IN_WIDTH),
    .ROW_SIZE        (ROW_SIZE),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .tree_in        (tree_in),
    .tree_in_valid  (tree_in_valid),
    .tree_in_ready  (tree_in_ready),
    .tree_out       (tree_out),
    .tree_out_valid (tree_out_valid),
    .tree_out_ready (tree_out_ready),
    .row_max        (row_max),
    .row_max_valid  (row_max_valid),
    .row_max_ready  (row_max_ready),
    .row_busy       (row_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // What the external tree returns for one chunk: max |element| as unsigned.
  function automatic logic [IN_WIDTH-1:0] tree_mag(input chunk_t c);
    logic [IN_WIDTH-1:0] m;
    logic [IN_WIDTH-1:0] a;
    m = '0;
    for (int e = 0; e < IN_SIZE; e++) begin
      a = c[e][IN_WIDTH-1] ? (~c[e] + 1'b1) : c[e];
      if (a > m) m = a;
    end
    return m;
  endfunction

  // Reference: absmax over every element of the row, in plain integers.
  function automatic logic [IN_WIDTH-1:0] ref_row_max();
    int best;
    int v;
    best = 0;
    for (int c = 0; c < CHUNKS; c++) begin
      for (int e = 0; e < IN_SIZE; e++) begin
        v = int'($signed(row_data[c][e]));
        if (v < 0) v = -v;
`ifdef ABSMAX_SATURATE_EN
        if (v == (1 << (IN_WIDTH - 1))) v = v - 1;
`endif
        if (v > best) best = v;
      end
    end
    return IN_WIDTH'(best);
  endfunction

  function automatic logic [15:0] rand_mag();
    if ($urandom_range(0, 7) == 0) return 16'h8000;
    return 16'($urandom_range(0, 32'h7FFF));
  endfunction

  // Build a row whose chunk k has max |element| exactly equal to mk.
  task automatic build_row(input logic [15:0] m0, input logic [15:0] m1,
                           input logic [15:0] m2, input logic [15:0] m3);
    logic [15:0] mags [CHUNKS];
    mags[0] = m0; mags[1] = m1; mags[2] = m2; mags[3] = m3;
    for (int c = 0; c < CHUNKS; c++) begin
      int pos;
      logic [15:0] lim;
      logic [15:0] v;
      pos = $urandom_range(0, IN_SIZE - 1);
      lim = (mags[c] == 16'h8000) ? 16'h7FFF : mags[c];
      for (int e = 0; e < IN_SIZE; e++) begin
        v = 16'($urandom_range(0, int'(lim)));
        if (e == pos) v = mags[c];
        row_data[c][e] = ($urandom_range(0, 1) == 1) ? (16'h0000 - v) : v;
      end
    end
  endtask

  // Drive one row cycle by cycle against the tree model; optionally reset mid-row.
  task automatic run_row(input int lat, input int in_rdy_pct, input int valid_pct,
                         input int stall, input int max_fly, input int abort_at);
    int sent = 0;
    int ret = 0;
    int fly = 0;
    int cyc = 0;
    int peak = 0;
    int stall_left;
    bit done = 0;
    bit can, in_fire, out_fire, emit, accept;
    int due_q[$];
    logic [IN_WIDTH-1:0] mag_q[$];
    logic [IN_WIDTH-1:0] exp_max;
    stall_left = stall;
    exp_max = ref_row_max();
    while (!done && cyc < 300) begin
      if (abort_at > 0 && sent == abort_at) begin
        data_in_valid  = 1'b1;
        tree_in_ready  = 1'b1;
        tree_out_valid = 1'b0;
        row_max_ready  = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_tree_in_valid", tree_in_valid, 1'b0);
        check("rst_data_in_ready", data_in_ready, 1'b0);
        check("rst_tree_out_ready", tree_out_ready, 1'b0);
        check("rst_row_busy", row_busy, 1'b0);
        check("rst_row_max_valid", row_max_valid, 1'b0);
        check("rst_row_max", row_max, '0);
        @(negedge clk);
        rst = 1'b1;
        data_in_valid = 1'b0;
        return;
      end
      data_in_valid  = (sent < CHUNKS) && ($urandom_range(0, 99) < valid_pct);
      data_in        = row_data[(sent < CHUNKS) ? sent : 0];
      tree_in_ready  = ($urandom_range(0, 99) < in_rdy_pct);
      tree_out_valid = (due_q.size() > 0) && (due_q[0] <= cyc);
      tree_out       = tree_out_valid ? mag_q[0] : 16'($urandom());
      row_max_ready  = (stall_left == 0);
      #1;
      can  = (sent < CHUNKS) && (fly < MAX_OUT);
      emit = (ret == CHUNKS);
      check("data_in_ready", data_in_ready, tree_in_ready && can);
      check("tree_in_valid", tree_in_valid, data_in_valid && can);
      if (data_in_valid && can) check("tree_in_data", tree_in, data_in);
      check("tree_out_ready", tree_out_ready, (sent > 0) && (ret < CHUNKS));
      check("row_max_valid", row_max_valid, emit);
      check("row_busy", row_busy, sent > 0);
      if (emit) check("row_max", row_max, exp_max);
      in_fire  = data_in_valid && can && tree_in_ready;
      out_fire = tree_out_valid && (sent > 0) && (ret < CHUNKS);
      accept   = emit && row_max_ready;
      @(posedge clk);
      if (in_fire) begin
        due_q.push_back(cyc + lat);
        mag_q.push_back(tree_mag(data_in));
        sent++;
        fly++;
      end
      if (out_fire) begin
        void'(due_q.pop_front());
        void'(mag_q.pop_front());
        ret++;
        fly--;
      end
      if (fly > peak) peak = fly;
      if (accept) done = 1'b1;
      else if (emit && stall_left > 0) stall_left--;
      @(negedge clk);
      cyc++;
    end
    check("row_completed", done, 1'b1);
    check("peak_in_flight_ok", peak <= max_fly, 1'b1);
    data_in_valid  = 1'b0;
    tree_out_valid = 1'b0;
    row_max_ready  = 1'b0;
    #1;
    check("post_row_busy", row_busy, 1'b0);
    check("post_row_max_valid", row_max_valid, 1'b0);
    check("post_row_max_cleared", row_max, '0);
  endtask

  initial begin
    rst            = 1'b0;
    data_in        = '0;
    data_in_valid  = 1'b1;
    tree_in_ready  = 1'b1;
    tree_out       = '0;
    tree_out_valid = 1'b0;
    row_max_ready  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_tree_in_valid", tree_in_valid, 1'b0);
    check("reset_data_in_ready", data_in_ready, 1'b0);
    check("reset_tree_out_ready", tree_out_ready, 1'b0);
    check("reset_row_max", row_max, '0);
    check("reset_row_max_valid", row_max_valid, 1'b0);
    check("reset_row_busy", row_busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    data_in_valid = 1'b0;

    // Basic row: chunk magnitudes 3, 9, 2, 7.
    build_row(16'd3, 16'd9, 16'd2, 16'd7);
    check("basic_ref", ref_row_max(), 16'd9);
    run_row(2, 100, 100, 0, MAX_OUT, 0);

    // Credit limit with a slow tree.
    build_row(rand_mag(), rand_mag(), rand_mag(), rand_mag());
    run_row(5, 100, 100, 0, MAX_OUT, 0);

    // Output backpressure for 10 cycles.
    build_row(rand_mag(), rand_mag(), rand_mag(), rand_mag());
    run_row(3, 100, 100, 10, MAX_OUT, 0);

    // Overflowed magnitude among small ones.
    build_row(16'h0100, 16'h8000, 16'h0050, 16'h00FF);
`ifdef ABSMAX_SATURATE_EN
    check("sat_ref", ref_row_max(), 16'h7FFF);
`else
    check("sat_ref", ref_row_max(), 16'h8000);
`endif
    run_row(2, 100, 100, 0, MAX_OUT, 0);

    // Latency-1 tree at full rate: issue and return coincide every cycle.
    build_row(rand_mag(), rand_mag(), rand_mag(), rand_mag());
    run_row(1, 100, 100, 0, 1, 0);

    // Reset after two chunks, then a clean row with small values.
    build_row(16'h7FF0, 16'h7FFF, 16'h7000, 16'h7100);
    run_row(2, 100, 100, 0, MAX_OUT, 2);
    build_row(16'd5, 16'd40, 16'd17, 16'd1);
    run_row(2, 100, 100, 0, MAX_OUT, 0);

    // Randomised rows with varied latency and handshake pressure.
    for (int r = 0; r < 10; r++) begin
      build_row(rand_mag(), rand_mag(), rand_mag(), rand_mag());
      run_row($urandom_range(1, 6), $urandom_range(40, 100), $urandom_range(40, 100),
              $urandom_range(0, 4), MAX_OUT, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
